// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Shared types and index helpers for the binary conv/pool layer.
//               State encoding, 3x3 kernel size, 9-bit popcount and the flat
//               bit-index maps for pixels, weights and layer outputs.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

    localparam int KERNEL = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] popcount9(input logic [8:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 9; k++) begin
            n = n + {3'b000, v[k]};
        end
        return n;
    endfunction

    // pixel[r][c] lives at bit r*img_w + c
    function automatic int pixel_index(input int r, input int c, input int img_w);
        return r * img_w + c;
    endfunction

    // kernel bit k[kr][kc][w]: taps outer, channel inner
    function automatic int weight_index(input int kr, input int kc, input int w,
                                        input int n_ch);
        return kr * KERNEL * n_ch + kc * n_ch + w;
    endfunction

    // out[w][r][c]: channel outer, row middle, column inner (also the scan order)
    function automatic int out_index(input int w, input int r, input int c,
                                     input int out_h, input int out_w);
        return w * out_h * out_w + r * out_w + c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_xnor_window.sv
`default_nettype none
// ============================================================================
// Module      : bnn_xnor_window
// Description : Combinational extraction of one zero-padded 3x3 window centred
//               on (row, col), XNORed tap-by-tap against one channel's kernel.
// Ports       : pixels  in  IMG_H*IMG_W  binary image, row-major
//               kernel  in  9            kernel bits, index kr*3+kc
//               row     in  centre row
//               col     in  centre column
//               match   out 9            1 where the tap equals its weight
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_xnor_window
    import bnn_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic [IMG_H*IMG_W-1:0]     pixels,
    input  logic [KERNEL*KERNEL-1:0]   kernel,
    input  logic [$clog2(IMG_H)-1:0]   row,
    input  logic [$clog2(IMG_W)-1:0]   col,
    output logic [KERNEL*KERNEL-1:0]   match
);

    localparam int PA_W = $clog2(IMG_H * IMG_W);

    always_comb begin
        int         yy;
        int         xx;
        logic       px;
        logic [3:0] t;
        match = '0;
        yy    = 0;
        xx    = 0;
        px    = 1'b0;
        t     = 4'd0;
        for (int kr = 0; kr < KERNEL; kr++) begin
            for (int kc = 0; kc < KERNEL; kc++) begin
                yy = int'(row) + kr - 1;
                xx = int'(col) + kc - 1;
                // Taps outside the image read as 0, so a 0 weight still matches.
                px = 1'b0;
                if (yy >= 0 && yy < IMG_H && xx >= 0 && xx < IMG_W) begin
                    px = pixels[PA_W'(pixel_index(yy, xx, IMG_W))];
                end
                t        = 4'(kr * KERNEL + kc);
                match[t] = ~(px ^ kernel[t]);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bnn_conv_pool.sv
`default_nettype none
// ============================================================================
// Module      : bnn_conv_pool
// Description : Binary conv layer: 3x3 XNOR-popcount convolution, per-channel
//               threshold, then 2x2 OR max-pool. One pooled output bit is
//               issued per cycle through a three-stage pipeline.
// Ports       : clk         in  clock, rising edge
//               rst_n       in  synchronous active-low reset
//               start       in  run one pass (accepted in IDLE or DONE)
//               pixels      in  IMG_H*IMG_W image, held while busy
//               weights     in  9*N_CH kernel bits, held while busy
//               thresholds  in  THR_W*N_CH per-channel thresholds
//               busy        out pass in progress
//               done        out pass complete, layer_out valid
//               layer_out   out N_CH*OUT_H*OUT_W pooled bitmap
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_conv_pool
    import bnn_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int N_CH  = 8,
    parameter int THR_W = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [IMG_H*IMG_W-1:0]               pixels,
    input  logic [9*N_CH-1:0]                    weights,
    input  logic [THR_W*N_CH-1:0]                thresholds,
    output logic                                 busy,
    output logic                                 done,
    output logic [N_CH*(IMG_H/2)*(IMG_W/2)-1:0]  layer_out
);

    localparam int OUT_W = IMG_W / 2;
    localparam int OUT_H = IMG_H / 2;
    localparam int N     = N_CH * OUT_H * OUT_W;
    localparam int CH_W  = (N_CH  > 1) ? $clog2(N_CH)  : 1;
    localparam int R_W   = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int C_W   = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int O_W   = (N     > 1) ? $clog2(N)     : 1;
    localparam int Y_W   = $clog2(IMG_H);
    localparam int X_W   = $clog2(IMG_W);
    localparam int NQ    = 4;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   ch;
    logic [R_W-1:0]    orow;
    logic [C_W-1:0]    ocol;
    logic [1:0]        drain_cnt;
    logic              accept, issue, last_issue;

    logic [8:0]        kern_all [N_CH];
    logic [THR_W-1:0]  thr_all  [N_CH];
    logic [8:0]        kern;
    logic [THR_W-1:0]  thr_sel;
    logic [Y_W-1:0]    yq       [NQ];
    logic [X_W-1:0]    xq       [NQ];
    logic [8:0]        match_q  [NQ];
    logic [O_W-1:0]    issue_idx;

    logic              s1_valid, s2_valid;
    logic [8:0]        s1_match [NQ];
    logic [CH_W-1:0]   s1_ch;
    logic [O_W-1:0]    s1_idx, s2_idx;
    logic [NQ-1:0]     s2_hit;

    // Per-channel views of the flat weight and threshold buses
    for (genvar w = 0; w < N_CH; w++) begin : g_chan
        for (genvar k = 0; k < 9; k++) begin : g_tap
            assign kern_all[w][k] = weights[weight_index(k / 3, k % 3, w, N_CH)];
        end
        assign thr_all[w] = thresholds[w*THR_W +: THR_W];
    end

    always_comb begin
        kern    = '0;
        thr_sel = '0;
        for (int w = 0; w < N_CH; w++) begin
            if (int'(ch) == w)    kern    = kern_all[w];
            if (int'(s1_ch) == w) thr_sel = thr_all[w];
        end
    end

    // One window per pool quadrant: centres (2r+dy, 2c+dx), q = dy*2 + dx
    for (genvar q = 0; q < NQ; q++) begin : g_quad
        assign yq[q] = Y_W'(2 * int'(orow) + q / 2);
        assign xq[q] = X_W'(2 * int'(ocol) + q % 2);
        bnn_xnor_window #(
            .IMG_W (IMG_W),
            .IMG_H (IMG_H)
        ) u_win (
            .pixels (pixels),
            .kernel (kern),
            .row    (yq[q]),
            .col    (xq[q]),
            .match  (match_q[q])
        );
    end

    assign issue_idx  = O_W'(out_index(int'(ch), int'(orow), int'(ocol), OUT_H, OUT_W));
    assign last_issue = (int'(ch) == N_CH - 1) && (int'(orow) == OUT_H - 1)
                     && (int'(ocol) == OUT_W - 1);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        issue     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                issue = 1'b1;
                if (last_issue) state_nxt = DRAIN;
            end
            // Three edges in DRAIN: stage 2 of the last index, its write,
            // then completion, so done rises one edge after the last write.
            DRAIN: begin
                if (drain_cnt == 2'd2) state_nxt = DONE;
            end
            DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ch        <= '0;
            orow      <= '0;
            ocol      <= '0;
            drain_cnt <= 2'd0;
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s1_ch     <= '0;
            s1_idx    <= '0;
            s2_idx    <= '0;
            s2_hit    <= '0;
            for (int q = 0; q < NQ; q++) s1_match[q] <= '0;
            layer_out <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;

            if (accept) begin
                ch   <= '0;
                orow <= '0;
                ocol <= '0;
            end else if (issue) begin
                if (int'(ocol) == OUT_W - 1) begin
                    ocol <= '0;
                    if (int'(orow) == OUT_H - 1) begin
                        orow <= '0;
                        ch   <= (int'(ch) == N_CH - 1) ? '0 : ch + CH_W'(1);
                    end else begin
                        orow <= orow + R_W'(1);
                    end
                end else begin
                    ocol <= ocol + C_W'(1);
                end
            end

            // Stage 1: capture the four XNOR vectors
            s1_valid <= issue;
            if (issue) begin
                for (int q = 0; q < NQ; q++) s1_match[q] <= match_q[q];
                s1_ch  <= ch;
                s1_idx <= issue_idx;
            end

            // Stage 2: popcount and unsigned threshold compare
            s2_valid <= s1_valid;
            if (s1_valid) begin
                for (int q = 0; q < NQ; q++) begin
                    s2_hit[q] <= (int'(popcount9(s1_match[q])) >= int'(thr_sel));
                end
                s2_idx <= s1_idx;
            end

            // Stage 3: pooled write
            if (s2_valid) layer_out[s2_idx] <= |s2_hit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bnn_conv_pool.sv
`default_nettype none
// ============================================================================
// Module      : tb_bnn_conv_pool
// Description : Scoreboard bench for bnn_conv_pool. Three instances: default
//               28x28x8, 4x4x2 and 4x4x1. Expected completion edge and output
//               are queued at start; a monitor pops on each done rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bnn_conv_pool;

    localparam int N_G = 1568;
    localparam int N_A = 8;
    localparam int N_B = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic            start_g = 1'b0, start_a = 1'b0, start_b = 1'b0;
    logic [783:0]    pix_g = '0;
    logic [71:0]     wts_g = '0;
    logic [31:0]     thr_g = '0;
    logic [15:0]     pix_a = '0, pix_b = '0;
    logic [17:0]     wts_a = '0;
    logic [8:0]      wts_b = '0;
    logic [7:0]      thr_a = '0;
    logic [3:0]      thr_b = '0;
    logic            busy_g, done_g, busy_a, done_a, busy_b, done_b;
    logic [N_G-1:0]  out_g;
    logic [N_A-1:0]  out_a;
    logic [N_B-1:0]  out_b;

    bnn_conv_pool u_g (
        .clk(clk), .rst_n(rst_n), .start(start_g), .pixels(pix_g), .weights(wts_g),
        .thresholds(thr_g), .busy(busy_g), .done(done_g), .layer_out(out_g)
    );

    bnn_conv_pool #(.IMG_W(4), .IMG_H(4), .N_CH(2), .THR_W(4)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .pixels(pix_a), .weights(wts_a),
        .thresholds(thr_a), .busy(busy_a), .done(done_a), .layer_out(out_a)
    );

    bnn_conv_pool #(.IMG_W(4), .IMG_H(4), .N_CH(1), .THR_W(4)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pixels(pix_b), .weights(wts_b),
        .thresholds(thr_b), .busy(busy_b), .done(done_b), .layer_out(out_b)
    );

    typedef struct {
        int         busy_edge;
        int         done_edge;
        logic [7:0] out;
    } exp_t;

    exp_t q_g[$];
    exp_t q_a[$];
    exp_t q_b[$];

    int   cyc      = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    logic busy_prev [3] = '{1'b0, 1'b0, 1'b0};
    logic done_prev [3] = '{1'b0, 1'b0, 1'b0};
    int   busy_rise [3] = '{0, 0, 0};
    int   busy_cnt  [3] = '{0, 0, 0};

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int qsz(input int id);
        case (id)
            0:       return q_g.size();
            1:       return q_a.size();
            default: return q_b.size();
        endcase
    endfunction

    function automatic bit pop(input int id, output exp_t e);
        e = '{0, 0, 8'h00};
        if (qsz(id) == 0) return 1'b0;
        case (id)
            0:       e = q_g.pop_front();
            1:       e = q_a.pop_front();
            default: e = q_b.pop_front();
        endcase
        return 1'b1;
    endfunction

    task automatic mon(input int id);
        logic   b, d;
        longint out_act, out_exp;
        exp_t   e;
        bit     have;
        string  nm;
        case (id)
            0: begin
                b = busy_g; d = done_g; nm = "g";
                out_act = (out_g == {N_G{1'b1}}) ? 1 : ((out_g == '0) ? 0 : 2);
            end
            1: begin b = busy_a; d = done_a; nm = "a"; out_act = longint'(out_a); end
            default: begin b = busy_b; d = done_b; nm = "b"; out_act = longint'(out_b); end
        endcase
        if (b === 1'b1 && busy_prev[id] !== 1'b1) begin
            busy_rise[id] = cyc;
            busy_cnt[id]  = 0;
        end
        if (b === 1'b1) busy_cnt[id]++;
        if (d === 1'b1 && done_prev[id] !== 1'b1) begin
            have = pop(id, e);
            chk({nm, "_done_expected"}, longint'(have), 1);
            if (have) begin
                case (id)
                    0:       out_exp = longint'(e.out[0]);
                    1:       out_exp = longint'(e.out);
                    default: out_exp = longint'(e.out[3:0]);
                endcase
                chk({nm, "_done_edge"},  cyc, e.done_edge);
                chk({nm, "_busy_start"}, busy_rise[id], e.busy_edge);
                chk({nm, "_busy_len"},   busy_cnt[id], e.done_edge - e.busy_edge);
                chk({nm, "_busy_at_done"}, longint'(b), 0);
                chk({nm, "_layer_out"},  out_act, out_exp);
            end
        end
        busy_prev[id] = b;
        done_prev[id] = d;
    endtask

    initial forever begin
        @(negedge clk);
        for (int id = 0; id < 3; id++) mon(id);
    end

    task automatic set_start(input int id, input logic v);
        case (id)
            0:       start_g = v;
            1:       start_a = v;
            default: start_b = v;
        endcase
    endtask

    // Pulses start for one cycle; accept edge is the next posedge.
    task automatic issue(input int id, input logic [7:0] exp_out, input bit push);
        exp_t e;
        int   n;
        @(negedge clk);
        n = (id == 0) ? N_G : ((id == 1) ? N_A : N_B);
        e.busy_edge = cyc + 1;
        e.done_edge = cyc + 1 + n + 3;
        e.out       = exp_out;
        if (push) begin
            case (id)
                0:       q_g.push_back(e);
                1:       q_a.push_back(e);
                default: q_b.push_back(e);
            endcase
        end
        set_start(id, 1'b1);
        @(negedge clk);
        set_start(id, 1'b0);
    endtask

    task automatic wait_done(input int id, input int budget);
        int k = 0;
        while (qsz(id) != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("pass_completed_in_budget", longint'(qsz(id) == 0), 1);
        case (id)
            0:       q_g.delete();
            1:       q_a.delete();
            default: q_b.delete();
        endcase
    endtask

    task automatic run_a(input logic [17:0] w, input logic [7:0] t, input logic [7:0] exp_out);
        wts_a = w;
        thr_a = t;
        issue(1, exp_out, 1'b1);
        wait_done(1, 40);
    endtask

    task automatic run_b(input logic [15:0] p, input logic [8:0] w, input logic [3:0] t,
                         input logic [3:0] exp_out);
        pix_b = p;
        wts_b = w;
        thr_b = t;
        issue(2, {4'h0, exp_out}, 1'b1);
        wait_done(2, 40);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("g_reset_busy", longint'(busy_g), 0);
        chk("g_reset_done", longint'(done_g), 0);
        chk("g_reset_out",  longint'(out_g == '0), 1);
        chk("a_reset_busy", longint'(busy_a), 0);
        chk("a_reset_done", longint'(done_a), 0);
        chk("a_reset_out",  longint'(out_a), 0);
        chk("b_reset_busy", longint'(busy_b), 0);
        chk("b_reset_done", longint'(done_b), 0);
        chk("b_reset_out",  longint'(out_b), 0);
        rst_n = 1'b1;

        // Default geometry: thr=0 forces all ones; done 1571 edges after accept
        issue(0, 8'h01, 1'b1);
        wait_done(0, N_G + 40);

        // 4x4x2, pixels 0
        pix_a = '0;
        run_a(18'h00000, 8'h55, 8'hFF);
        run_a(18'h3FFFF, 8'h55, 8'h00);
        run_a(18'h00000, 8'h99, 8'hFF);
        run_a(18'h00000, 8'hAA, 8'h00);
        run_a(18'h00000, 8'hA9, 8'h0F);
        run_a(18'h3FFFF, 8'h00, 8'hFF);

        // ch0 kernel all 0, ch1 all 1; start re-pulsed at edges 3 and 7
        wts_a = 18'h2AAAA;
        thr_a = 8'h55;
        issue(1, 8'h0F, 1'b1);
        repeat (2) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (3) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_done(1, 40);

        // Back-to-back start from DONE
        wts_a = 18'h00000;
        thr_a = 8'h55;
        issue(1, 8'hFF, 1'b1);
        chk("a_done_cleared_on_accept", longint'(done_a), 0);
        chk("a_busy_on_accept", longint'(busy_a), 1);
        wait_done(1, 40);

        // Reset at edge 5 of a run aborts it and clears the outputs
        issue(1, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("a_midrun_rst_busy", longint'(busy_a), 0);
        chk("a_midrun_rst_done", longint'(done_a), 0);
        chk("a_midrun_rst_out",  longint'(out_a), 0);
        rst_n = 1'b1;
        run_a(18'h00000, 8'hA9, 8'h0F);

        // 4x4x1 single-channel patterns
        run_b(16'h0020, 9'h1FF, 4'd1, 4'b1111);
        run_b(16'h0020, 9'h1FF, 4'd2, 4'b0000);
        run_b(16'h0021, 9'h1FF, 4'd2, 4'b0001);
        run_b(16'h0001, 9'h100, 4'd8, 4'b1110);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
